signed_mac_acc: RTL

- Sequential accumulator directly downstream of the 32x32 signed multiplier.
- Consumes the multiplier's 64-bit two's-complement product and sums a frame of N products into a wider signed accumulator.
- Returns the frame total with a valid/ready handshake.
- Used for dot-product / FIR-style reductions on top of the combinational multiplier array.

---
 rtl/signed_mac_acc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/signed_mac_acc.sv
// Frame accumulator for signed multiplier products, with a valid/ready result handshake.
// Define SIGNED_MAC_SAT_EN to clamp on overflow; otherwise the sum wraps modulo 2^ACC_W.
module signed_mac_acc #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   len_q,   len_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_upd;
    logic [CNT_W-1:0]   cnt_inc;
    logic               add_ovf;

    assign prod_ext = ACC_W'($signed(in_prod));
    assign sum      = acc_q + prod_ext;
    assign cnt_inc  = cnt_q + 1'b1;

    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1]   != acc_q[ACC_W-1]);

`ifdef SIGNED_MAC_SAT_EN
    always_comb begin
        acc_upd = sum;
        if (add_ovf) begin
            acc_upd = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_upd = sum;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = frame_len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = (frame_len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = acc_upd;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_valid = (state_q == S_DONE);
    assign in_ready  = (state_q == S_ACC);
    assign busy      = (state_q != S_IDLE);

endmodule
